// File: rtl/fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect_ctrl
// Purpose  : Flushes fetch, drains in-flight fetches, then sets the new PC and
//            pulses restart for branch and interrupt redirects.
// Options  : FETCH_REDIRECT_TIMEOUT_EN enables the FLUSH drain watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_redirect_ctrl #(
  parameter int          OUTST_W       = 4,
  parameter logic [31:0] IRQ_BASE      = 32'h0000_0100,
  parameter int          DRAIN_TIMEOUT = 64
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iBRANCH_VALID,
  input  logic [31:0] iBRANCH_ADDR,
  output logic        oBRANCH_ACK,
  input  logic        iIRQ_VALID,
  input  logic [7:0]  iIRQ_VECTOR,
  output logic        oIRQ_ACK,
  input  logic        iFETCH_REQ,
  input  logic        iFETCH_ACK,
  output logic        oEXCEPTION_EVENT,
  output logic        oEXCEPTION_ADDR_SET,
  output logic [31:0] oEXCEPTION_ADDR,
  output logic        oEXCEPTION_RESTART,
  output logic        oBUSY,
  output logic        oCNT_ERR,
  output logic        oTIMEOUT
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FLUSH   = 2'd1,
    S_SET     = 2'd2,
    S_RESTART = 2'd3
  } state_t;

  localparam logic [OUTST_W-1:0] CNT_MAX = '1;

  state_t             state;
  logic [OUTST_W-1:0] outst;
  logic [OUTST_W-1:0] outst_next;
  logic               cnt_err_hit;
  logic               drained;
  logic               tmo_fire;
  logic [31:0]        branch_tgt;
  logic [31:0]        irq_sum;
  logic [31:0]        irq_tgt;

  if (DRAIN_TIMEOUT < 1) begin : g_bad_drain_timeout
    $error("fetch_redirect_ctrl: DRAIN_TIMEOUT must be at least 1");
  end

  // Outstanding fetch tracking runs in every state, independent of the FSM.
  always_comb begin
    outst_next = outst;
    unique case ({iFETCH_REQ, iFETCH_ACK})
      2'b10:   if (outst != CNT_MAX) outst_next = outst + 1'b1;
      2'b01:   if (outst != '0)      outst_next = outst - 1'b1;
      default: outst_next = outst;
    endcase
  end

  assign cnt_err_hit = iFETCH_ACK && (outst == '0);
  assign drained     = (outst == '0) && !iFETCH_ACK;

  assign branch_tgt = {iBRANCH_ADDR[31:1], 1'b0};
  assign irq_sum    = IRQ_BASE + {22'd0, iIRQ_VECTOR, 2'b00};
  assign irq_tgt    = {irq_sum[31:1], 1'b0};

`ifdef FETCH_REDIRECT_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRAIN_TIMEOUT - 1);

  logic [TMO_W-1:0] flush_cycles;

  assign tmo_fire = (state == S_FLUSH) && !drained && (flush_cycles == TMO_LAST);

  // Held at zero outside FLUSH so every FLUSH entry starts a fresh count.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      flush_cycles <= '0;
      oTIMEOUT     <= 1'b0;
    end else begin
      if (state != S_FLUSH) begin
        flush_cycles <= '0;
      end else if (!tmo_fire) begin
        flush_cycles <= flush_cycles + 1'b1;
      end
      if (tmo_fire) begin
        oTIMEOUT <= 1'b1;
      end
    end
  end
`else
  assign tmo_fire = 1'b0;
  assign oTIMEOUT = 1'b0;
`endif

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state               <= S_IDLE;
      outst               <= '0;
      oCNT_ERR            <= 1'b0;
      oBRANCH_ACK         <= 1'b0;
      oIRQ_ACK            <= 1'b0;
      oEXCEPTION_EVENT    <= 1'b0;
      oEXCEPTION_ADDR_SET <= 1'b0;
      oEXCEPTION_ADDR     <= 32'd0;
      oEXCEPTION_RESTART  <= 1'b0;
      oBUSY               <= 1'b0;
    end else begin
      oBRANCH_ACK         <= 1'b0;
      oIRQ_ACK            <= 1'b0;
      oEXCEPTION_ADDR_SET <= 1'b0;
      oEXCEPTION_RESTART  <= 1'b0;
      outst               <= tmo_fire ? '0 : outst_next;
      if (cnt_err_hit) begin
        oCNT_ERR <= 1'b1;
      end

      unique case (state)
        S_IDLE: begin
          oEXCEPTION_EVENT <= 1'b0;
          oBUSY            <= 1'b0;
          // Interrupt wins; a simultaneous branch simply stays pending.
          if (iIRQ_VALID) begin
            oEXCEPTION_ADDR  <= irq_tgt;
            oIRQ_ACK         <= 1'b1;
            oEXCEPTION_EVENT <= 1'b1;
            oBUSY            <= 1'b1;
            state            <= S_FLUSH;
          end else if (iBRANCH_VALID) begin
            oEXCEPTION_ADDR  <= branch_tgt;
            oBRANCH_ACK      <= 1'b1;
            oEXCEPTION_EVENT <= 1'b1;
            oBUSY            <= 1'b1;
            state            <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (drained || tmo_fire) begin
            oEXCEPTION_ADDR_SET <= 1'b1;
            state               <= S_SET;
          end
        end
        S_SET: begin
          oEXCEPTION_EVENT   <= 1'b0;
          oEXCEPTION_RESTART <= 1'b1;
          state              <= S_RESTART;
        end
        S_RESTART: begin
          oBUSY <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect_ctrl.sv
`default_nettype none
// Testbench for fetch_redirect_ctrl: directed literal checks plus a randomized
// run compared every cycle against a timeline model of each redirect.
module tb_fetch_redirect_ctrl;

  localparam int          OUTST_W       = 4;
  localparam int          CNT_MAX       = (1 << OUTST_W) - 1;
  localparam logic [31:0] IRQ_BASE      = 32'h0000_0100;
  localparam int          DRAIN_TIMEOUT = 64;
`ifdef FETCH_REDIRECT_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bv = 1'b0;
  logic [31:0] ba = 32'd0;
  logic        iv = 1'b0;
  logic [7:0]  ivec = 8'd0;
  logic        freq = 1'b0;
  logic        fack = 1'b0;
  logic        back, iack, evt, aset, rstrt, busy, cerr, tmo;
  logic [31:0] eaddr;

  int total = 0;
  int bad   = 0;

  fetch_redirect_ctrl #(
    .OUTST_W(OUTST_W), .IRQ_BASE(IRQ_BASE), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) dut (
    .iCLOCK(clk), .inRESET(rst_n),
    .iBRANCH_VALID(bv), .iBRANCH_ADDR(ba), .oBRANCH_ACK(back),
    .iIRQ_VALID(iv), .iIRQ_VECTOR(ivec), .oIRQ_ACK(iack),
    .iFETCH_REQ(freq), .iFETCH_ACK(fack),
    .oEXCEPTION_EVENT(evt), .oEXCEPTION_ADDR_SET(aset), .oEXCEPTION_ADDR(eaddr),
    .oEXCEPTION_RESTART(rstrt), .oBUSY(busy), .oCNT_ERR(cerr), .oTIMEOUT(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a redirect is a timeline counted from its accept edge. Cycle 1 is
  // the ack cycle; once the drain rule is met at the end of flush cycle k the
  // address set lands on cycle k+1 and restart on k+2, then the block is idle.
  int          m_cnt = 0;
  int          m_since = 0;
  int          m_set_at = 0;
  int          m_who = 0;
  bit          m_cerr = 1'b0;
  bit          m_tmo = 1'b0;
  logic [31:0] m_addr = 32'd0;

  function automatic bit f_evt();
    return (m_since != 0) && (m_set_at == 0 || m_since <= m_set_at);
  endfunction

  initial begin
    int nc;
    bit clr;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cnt = 0; m_since = 0; m_set_at = 0; m_who = 0;
        m_cerr = 1'b0; m_tmo = 1'b0; m_addr = 32'd0;
      end else begin
        clr = 1'b0;
        nc  = m_cnt;
        if (freq && !fack) nc = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
        if (fack && !freq) nc = (m_cnt == 0) ? 0 : m_cnt - 1;
        if (fack && m_cnt == 0) m_cerr = 1'b1;
        if (m_since == 0) begin
          if (iv) begin
            m_since = 1; m_set_at = 0; m_who = 2;
            m_addr = (IRQ_BASE + ({24'd0, ivec} << 2)) & 32'hFFFF_FFFE;
          end else if (bv) begin
            m_since = 1; m_set_at = 0; m_who = 1;
            m_addr = ba & 32'hFFFF_FFFE;
          end
        end else if (m_set_at == 0) begin
          if (m_cnt == 0 && !fack) begin
            m_set_at = m_since + 1;
          end else if (TMO_EN && m_since == DRAIN_TIMEOUT) begin
            m_set_at = m_since + 1; clr = 1'b1; m_tmo = 1'b1;
          end
          m_since++;
        end else if (m_since == m_set_at + 1) begin
          m_since = 0;
        end else begin
          m_since++;
        end
        m_cnt = clr ? 0 : nc;
      end
    end
  end

  bit cmp_en = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("m_busy",    32'(busy),  32'(m_since != 0));
        chk("m_br_ack",  32'(back),  32'(m_since == 1 && m_who == 1));
        chk("m_irq_ack", 32'(iack),  32'(m_since == 1 && m_who == 2));
        chk("m_event",   32'(evt),   32'(f_evt()));
        chk("m_addr_set",32'(aset),  32'(m_set_at != 0 && m_since == m_set_at));
        chk("m_restart", 32'(rstrt), 32'(m_set_at != 0 && m_since == m_set_at + 1));
        chk("m_addr",    eaddr,      m_addr);
        chk("m_cnt_err", 32'(cerr),  32'(m_cerr));
        chk("m_timeout", 32'(tmo),   32'(m_tmo));
      end
    end
  end

  initial begin
    int set_idx;
    int ack_idx;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_event", 32'(evt), 32'd0);
    chk("rst_addr", eaddr, 32'd0);

    // Single branch, nothing in flight.
    bv = 1'b1; ba = 32'h0000_2003;
    @(negedge clk);
    chk("t1_ack", 32'(back), 32'd1);
    chk("t1_event_c1", 32'(evt), 32'd1);
    chk("t1_addr", eaddr, 32'h0000_2002);
    bv = 1'b0;
    @(negedge clk);
    chk("t1_addr_set", 32'(aset), 32'd1);
    chk("t1_event_c2", 32'(evt), 32'd1);
    @(negedge clk);
    chk("t1_restart", 32'(rstrt), 32'd1);
    chk("t1_event_c3", 32'(evt), 32'd0);
    @(negedge clk);
    chk("t1_idle", 32'(busy), 32'd0);

    // Three fetches in flight, returned on cycles 2, 4 and 6.
    freq = 1'b1;
    repeat (3) @(negedge clk);
    freq = 1'b0; bv = 1'b1; ba = 32'h0000_4000;
    set_idx = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) bv = 1'b0;
      if (aset && set_idx == 0) set_idx = k;
      fack = (k == 2 || k == 4 || k == 6);
    end
    fack = 1'b0;
    chk("t2_set_cycle", 32'(set_idx), 32'd8);

    // IRQ and branch together: IRQ first, branch taken after restart.
    iv = 1'b1; ivec = 8'h05; bv = 1'b1; ba = 32'h0000_8001;
    ack_idx = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("t3_irq_ack", 32'(iack), 32'd1);
        chk("t3_br_not_ack", 32'(back), 32'd0);
        chk("t3_irq_addr", eaddr, 32'h0000_0114);
        iv = 1'b0;
      end
      if (back && ack_idx == 0) ack_idx = k;
      if (k == 5) begin
        chk("t3_br_addr", eaddr, 32'h0000_8000);
        bv = 1'b0;
      end
    end
    chk("t3_br_ack_cycle", 32'(ack_idx), 32'd5);

    // Stray fetch ack with nothing outstanding.
    fack = 1'b1;
    @(negedge clk);
    fack = 1'b0;
    chk("t4_cnt_err", 32'(cerr), 32'd1);
    repeat (3) @(negedge clk);
    chk("t4_cnt_err_sticky", 32'(cerr), 32'd1);

    // Saturation: 20 requests leave 15 outstanding, so 15 acks fully drain.
    freq = 1'b1;
    repeat (20) @(negedge clk);
    freq = 1'b0; bv = 1'b1; ba = 32'h0000_A000;
    set_idx = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 1) bv = 1'b0;
      if (aset && set_idx == 0) set_idx = k;
      fack = (k >= 2 && k <= 16);
    end
    fack = 1'b0;
    chk("t7_sat_set_cycle", 32'(set_idx), 32'd18);

    // Async reset in the middle of a stalled FLUSH.
    freq = 1'b1;
    repeat (2) @(negedge clk);
    freq = 1'b0; bv = 1'b1; ba = 32'h0000_3000;
    @(negedge clk);
    bv = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_event", 32'(evt), 32'd0);
    chk("t5_addr", eaddr, 32'd0);
    chk("t5_cnt_err", 32'(cerr), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    bv = 1'b1; ba = 32'h0000_5005;
    set_idx = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) bv = 1'b0;
      if (aset && set_idx == 0) set_idx = k;
    end
    chk("t5_count_cleared", 32'(set_idx), 32'd2);
    chk("t5_new_addr", eaddr, 32'h0000_5004);

`ifdef FETCH_REDIRECT_TIMEOUT_EN
    // One fetch that never returns: watchdog forces the set.
    freq = 1'b1;
    @(negedge clk);
    freq = 1'b0; bv = 1'b1; ba = 32'h0000_6000;
    set_idx = 0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (k == 1) bv = 1'b0;
      if (aset && set_idx == 0) set_idx = k;
    end
    chk("t6_tmo_set_cycle", 32'(set_idx), 32'd65);
    chk("t6_timeout", 32'(tmo), 32'd1);
    bv = 1'b1; ba = 32'h0000_7000;
    set_idx = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) bv = 1'b0;
      if (aset && set_idx == 0) set_idx = k;
    end
    chk("t6_count_zeroed", 32'(set_idx), 32'd2);
`endif

    // Randomized traffic; fetch does not issue while it is being flushed.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (bv && m_since == 1 && m_who == 1) bv = 1'b0;
      else if (!bv && $urandom_range(0, 3) == 0) begin bv = 1'b1; ba = $urandom; end
      if (iv && m_since == 1 && m_who == 2) iv = 1'b0;
      else if (!iv && $urandom_range(0, 5) == 0) begin iv = 1'b1; ivec = 8'($urandom); end
      freq = !f_evt() && ($urandom_range(0, 2) == 0);
      fack = ((m_cnt > 0) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 299) == 0);
    end
    bv = 1'b0; iv = 1'b0; freq = 1'b0; fack = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
